// File: rtl/bcd_to_binary.sv
// ---------------------------------------------------------------------------
// bcd_to_binary
//
// Purpose:
//   Converts four packed BCD digits into a 14-bit binary value with a small
//   sequential datapath. Each conversion takes one accept cycle, four
//   multiply-by-ten-and-add steps (one digit per clock, thousands first) and
//   a result hold in DONE until the consumer takes it.
//
// Ports:
//   clk        in   1   rising-edge clock for all state
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   bcd holds a request
//   in_ready   out  1   block can accept a request (state == IDLE)
//   bcd        in   16  packed BCD digits, [15:12] thousands .. [3:0] units
//   out_valid  out  1   binary/error hold a result
//   out_ready  in   1   consumer takes the result
//   binary     out  14  converted value
//   error      out  1   at least one input digit was greater than 9
//
// Handshakes: a transfer happens on the rising edge where valid && ready are
// both high. The producer holds data stable while valid is high and ready is
// low. Here, in_ready is high only in IDLE, and out_valid with its data stays
// asserted and unchanged until out_ready is seen.
//
// Configuration:
//   BCD2BIN_ERRCHK_EN  defined   -> digits > 9 flag error and force the
//                                   result to 14'h3FFF
//                      undefined -> error is constant 0 and invalid digits
//                                   are accumulated arithmetically (mod 2^14)
// ---------------------------------------------------------------------------
module bcd_to_binary (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] bcd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [13:0] binary,
   output logic        error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;

   logic [1:0]  cnt_q;
   logic [13:0] acc_q;
   logic [15:0] dig_q;
   logic        out_valid_q;
   logic [13:0] binary_q;

   logic [3:0]  digit;
   logic [13:0] acc_next;
   logic [13:0] result;
   logic        accept;
   logic        last_digit;
   logic        handshake;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and control decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      last_digit = 1'b0;
      handshake  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               state_d = CONV;
            end
         end
         CONV: begin
            if (cnt_q == 2'd3) begin
               last_digit = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            // out_valid is always high in DONE, so out_ready alone completes
            // the handshake.
            if (out_ready) begin
               handshake = 1'b1;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready = (state_q == IDLE);

   // ------------------------------------------------------------------------
   // Datapath: acc*10 + digit as two shifts and adds, truncated to 14 bits.
   // ------------------------------------------------------------------------
   assign digit    = dig_q[15:12];
   assign acc_next = {acc_q[10:0], 3'b000} + {acc_q[12:0], 1'b0} + {10'd0, digit};

`ifdef BCD2BIN_ERRCHK_EN
   logic err_int_q;
   logic err_next;
   logic error_q;

   assign err_next = err_int_q | (digit > 4'd9);
   assign result   = err_next ? 14'h3FFF : acc_next;
   assign error    = error_q;
`else
   assign result   = acc_next;
   assign error    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= 2'd0;
         acc_q       <= 14'd0;
         dig_q       <= 16'd0;
         out_valid_q <= 1'b0;
         binary_q    <= 14'd0;
`ifdef BCD2BIN_ERRCHK_EN
         err_int_q   <= 1'b0;
         error_q     <= 1'b0;
`endif
      end else begin
         if (accept) begin
            // bcd is captured here; later changes on the input are ignored.
            dig_q     <= bcd;
            acc_q     <= 14'd0;
            cnt_q     <= 2'd0;
`ifdef BCD2BIN_ERRCHK_EN
            err_int_q <= 1'b0;
`endif
         end else if (state_q == CONV) begin
            acc_q     <= acc_next;
            dig_q     <= {dig_q[11:0], 4'b0000};
            cnt_q     <= cnt_q + 2'd1;
`ifdef BCD2BIN_ERRCHK_EN
            err_int_q <= err_next;
`endif
            if (last_digit) begin
               binary_q    <= result;
               out_valid_q <= 1'b1;
`ifdef BCD2BIN_ERRCHK_EN
               error_q     <= err_next;
`endif
            end
         end

         // binary/error keep their last values after the result is taken.
         if (handshake) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign binary    = binary_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] bcd;
   logic        out_valid;
   logic        out_ready;
   logic [13:0] binary;
   logic        error;

   int checks = 0;
   int errors = 0;
   int lat;

   bcd_to_binary dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd       (bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .binary    (binary),
      .error     (error)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to 1 ns after the next rising edge; inputs are driven and
   // outputs sampled there
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // present v, accept on the next edge, drive v2 on bcd afterwards, then
   // wait (bounded) for out_valid; lat = edges from accept to out_valid
   task automatic do_req(input logic [15:0] v, input logic [15:0] v2, output int l);
      bcd      = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      bcd      = v2;
      l = 0;
      while (!out_valid && l < 20) begin
         tick();
         l++;
      end
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      tick();
      check("take_out_valid", out_valid, 1'b0);
      check("take_in_ready", in_ready, 1'b1);
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      bcd       = 16'h0000;
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_binary", binary, 14'd0);
      check("rst_error", error, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_in_ready", in_ready, 1'b1);

      // 9999 with exact latency
      do_req(16'h9999, 16'h9999, lat);
      check("9999_latency", lat, 4);
      check("9999_binary", binary, 14'h270F);
      check("9999_error", error, 1'b0);
      check("9999_in_ready_busy", in_ready, 1'b0);
      take_result();

      // back-to-back 0 then 1 with in_valid and out_ready held
      bcd       = 16'h0000;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();                       // accept T
      bcd = 16'h0001;
      check("b2b_busy", in_ready, 1'b0);
      tick(); tick(); tick();
      check("b2b_early", out_valid, 1'b0);
      tick();                       // T+4
      check("b2b_v0", out_valid, 1'b1);
      check("b2b_bin0", binary, 14'd0);
      tick();                       // T+5
      check("b2b_idle", in_ready, 1'b1);
      check("b2b_v0_clear", out_valid, 1'b0);
      tick();                       // T+6: second accept
      check("b2b_accept2", in_ready, 1'b0);
      in_valid = 1'b0;
      tick(); tick(); tick(); tick();
      check("b2b_v1", out_valid, 1'b1);
      check("b2b_bin1", binary, 14'd1);
      tick();
      check("b2b_idle2", in_ready, 1'b1);
      out_ready = 1'b0;

      // invalid digit
      do_req(16'h12A4, 16'h0000, lat);
      check("12a4_latency", lat, 4);
`ifdef BCD2BIN_ERRCHK_EN
      check("12a4_binary", binary, 14'h3FFF);
      check("12a4_error", error, 1'b1);
`else
      check("12a4_binary", binary, 14'd1304);
      check("12a4_error", error, 1'b0);
`endif
      take_result();

      // all digits invalid: wraps modulo 2^14 without checking
      do_req(16'hFFFF, 16'h0000, lat);
`ifdef BCD2BIN_ERRCHK_EN
      check("ffff_binary", binary, 14'h3FFF);
      check("ffff_error", error, 1'b1);
`else
      check("ffff_binary", binary, 14'd281);
      check("ffff_error", error, 1'b0);
`endif
      take_result();

      // backpressure: 420 held for 5 cycles, new request ignored
      do_req(16'h0420, 16'h0420, lat);
      check("420_latency", lat, 4);
      bcd      = 16'h0999;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", out_valid, 1'b1);
         check("hold_binary", binary, 14'd420);
         check("hold_in_ready", in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("420_released", out_valid, 1'b0);
      check("420_idle", in_ready, 1'b1);
      check("420_binary_kept", binary, 14'd420);
      tick();                       // out_ready high while idle: no effect
      check("idle_ready_noeffect", out_valid, 1'b0);
      check("idle_in_ready", in_ready, 1'b1);
      out_ready = 1'b0;

      // async reset during the 2nd CONV cycle of 5678
      bcd      = 16'h5678;
      in_valid = 1'b1;
      tick();                       // accept
      in_valid = 1'b0;
      tick();                       // 2nd CONV cycle
      #2;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_binary", binary, 14'd0);
      check("midrst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      lat = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid) lat++;
      end
      check("midrst_no_result", lat, 0);
      do_req(16'h0007, 16'h0007, lat);
      check("0007_latency", lat, 4);
      check("0007_binary", binary, 14'd7);
      take_result();

      // bcd changed after accept does not affect the result
      do_req(16'h1111, 16'h2222, lat);
      check("1111_latency", lat, 4);
      check("1111_binary", binary, 14'd1111);
      take_result();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
